// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fpu_op_sequencer                                               |
// | Brief   : Runs one FP op at a time through shared add/sub/mul/div units,  |
// |           with a watchdog abort for hung units.                          |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fpu_op_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  logic [OP_WIDTH-1:0]   req_op,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [OP_WIDTH-1:0]   mux_sel,
  output logic [3:0]            unit_start,
  input  logic [3:0]            unit_done,
  input  logic [DATA_WIDTH-1:0] mux_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err,
  output logic                  busy
);

  localparam int c_WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_op_a;
  logic [DATA_WIDTH-1:0] r_op_b;
  logic [OP_WIDTH-1:0]   r_mux_sel;
  logic [DATA_WIDTH-1:0] r_res_data;
  logic                  r_res_err;
  logic [c_WD_W-1:0]     r_wdog;
  logic                  w_done;
  logic                  w_expire;
  logic [3:0]            w_start;

  // Only the selected unit's done counts; the others may toggle freely.
  assign w_done   = unit_done[r_mux_sel];
  assign w_expire = (r_wdog == c_WD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 4'b0000;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        w_start[r_mux_sel] = 1'b1;
        w_next             = S_WAIT;
      end
      S_WAIT: begin
        if (w_done || w_expire) w_next = S_DONE;
      end
      S_DONE: begin
        if (res_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a     <= '0;
      r_op_b     <= '0;
      r_mux_sel  <= '0;
      r_res_data <= '0;
      r_res_err  <= 1'b0;
      r_wdog     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op_a    <= req_a;
            r_op_b    <= req_b;
            r_mux_sel <= req_op;
          end
        end
        S_ISSUE: begin
          r_wdog <= '0;
        end
        S_WAIT: begin
          // A done arriving on the last watchdog cycle still wins.
          if (w_done) begin
            r_res_data <= mux_result;
            r_res_err  <= 1'b0;
          end else if (w_expire) begin
            r_res_data <= '0;
            r_res_err  <= 1'b1;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign mux_sel    = r_mux_sel;
  assign unit_start = w_start;
  assign res_data   = r_res_data;
  assign res_err    = r_res_err;
  assign req_ready  = (r_state == S_IDLE);
  assign res_valid  = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
